pc_sequencer: RTL



---
 rtl/pc_sequencer_pkg.sv | 42 ++++
 rtl/pc_sequencer_adder.sv | 55 +++++
 rtl/pc_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// pc_seq_pkg: shared types and constants for the pc_sequencer slice.
//
// Contents:
//   word_t         16-bit machine word (program counter, offsets, targets)
//   state_t        sequencer FSM states {BOOT, FETCH, DECIDE, HALT}
//   redir_t        PC update source {SEQ, BR, JMP, HOLD}
//   DEF_*          default vectors and the default adder gate delay
//   nand2()        single NAND gate; the PC adder is built only from this
package pc_seq_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    DECIDE = 2'd2,
    HALT   = 2'd3
  } state_t;

  // SEQ  : pc + INC through the adder
  // BR   : pc + br_offset through the adder
  // JMP  : absolute target, adder bypassed
  // HOLD : pc keeps its value
  typedef enum logic [1:0] {
    SEQ  = 2'd0,
    BR   = 2'd1,
    JMP  = 2'd2,
    HOLD = 2'd3
  } redir_t;

  localparam word_t DEF_RESET_VEC = 16'h0000;
  localparam word_t DEF_INC       = 16'h0001;
  localparam word_t DEF_TRAP_VEC  = 16'hFFF0;

  // Gate delay of one NAND in the adder, in nanoseconds.
  localparam realtime DEF_NAND_TIME = 7.0;

  function automatic logic nand2(input logic a, input logic b);
    return ~(a & b);
  endfunction

endpackage

// File: rtl/pc_sequencer_adder.sv
// pc_adder: 16-bit ripple-carry adder built entirely from NAND gates.
// Sum is modulo 2^16; the carry out of bit 15 is dropped.
//
// Parameters:
//   NAND_TIME  gate delay of one NAND (ns). The ripple path is 16 full-adder
//              carry stages deep, so the sequencer clock period has to cover
//              that chain plus register setup.
// Ports:
//   a    in  16  first operand (always the current pc)
//   b    in  16  second operand (INC or branch offset)
//   sum  out 16  a + b, carry discarded
module pc_adder
  import pc_seq_pkg::*;
#(
  parameter realtime NAND_TIME = DEF_NAND_TIME
) (
  input  word_t a,
  input  word_t b,
  output word_t sum
);

  // A non-positive gate delay makes the timing budget meaningless.
  if (NAND_TIME <= 0.0) begin : g_bad_nand_time
    $error("pc_adder: NAND_TIME must be positive");
  end

  // Classic nine-NAND full adder per bit:
  //   n1 = a NAND b, x = a XOR b (n1..n3 + NAND), sum = x XOR c (n4..n6 + NAND),
  //   cout = n1 NAND n4.
  always_comb begin
    logic c;
    logic n1, n2, n3, x, n4, n5, n6;
    c   = 1'b0;
    n1  = 1'b0;
    n2  = 1'b0;
    n3  = 1'b0;
    x   = 1'b0;
    n4  = 1'b0;
    n5  = 1'b0;
    n6  = 1'b0;
    sum = '0;
    for (int i = 0; i < 16; i++) begin
      n1     = nand2(a[i], b[i]);
      n2     = nand2(a[i], n1);
      n3     = nand2(b[i], n1);
      x      = nand2(n2, n3);
      n4     = nand2(x, c);
      n5     = nand2(x, n4);
      n6     = nand2(c, n4);
      sum[i] = nand2(n5, n6);
      c      = nand2(n1, n4);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the 16-bit program counter and sequences instruction
// fetch. One pc_adder instance is shared between sequential increment and
// PC-relative branch targets; absolute jumps and trap/reset vectors bypass it.
//
// Optional feature: define PC_TRAP_EN to add the trap_valid input and the
// epc output (exception pc). Without it the ports do not exist.
//
// Handshake: imem_req is high exactly while in FETCH, and imem_addr (= pc) is
// held constant for that whole time. The fetch completes on the first rising
// edge where imem_req and imem_ack are both high; imem_ack is ignored in every
// other state. instr_valid is high exactly while in DECIDE, which is also the
// only state where stall/br/jmp/halt are looked at.
//
// Ports:
//   clk          in   1   clock
//   rst_n        in   1   asynchronous active-low reset
//   imem_req     out  1   fetch request
//   imem_addr    out  16  fetch address (equals pc)
//   imem_ack     in   1   fetch complete
//   instr_valid  out  1   fetched instruction presented to decode
//   stall        in   1   hold current instruction in DECIDE
//   br_valid     in   1   take PC-relative branch
//   br_offset    in   16  two's-complement offset from current pc
//   jmp_valid    in   1   take absolute jump
//   jmp_target   in   16  absolute jump target
//   halt         in   1   park after current instruction
//   resume       in   1   leave HALT
//   halted       out  1   sequencer parked
//   pc           out  16  current pc register
//   trap_valid   in   1   (PC_TRAP_EN) redirect to TRAP_VEC
//   epc          out  16  (PC_TRAP_EN) pc captured when a trap is taken
//   fsm_state    out  2   current FSM state, for observation
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter word_t   RESET_VEC = DEF_RESET_VEC,
  parameter word_t   INC       = DEF_INC,
`ifdef PC_TRAP_EN
  parameter word_t   TRAP_VEC  = DEF_TRAP_VEC,
`endif
  parameter realtime NAND_TIME = DEF_NAND_TIME
) (
  input  logic   clk,
  input  logic   rst_n,
  output logic   imem_req,
  output word_t  imem_addr,
  input  logic   imem_ack,
  output logic   instr_valid,
  input  logic   stall,
  input  logic   br_valid,
  input  word_t  br_offset,
  input  logic   jmp_valid,
  input  word_t  jmp_target,
  input  logic   halt,
  input  logic   resume,
  output logic   halted,
  output word_t  pc,
`ifdef PC_TRAP_EN
  input  logic   trap_valid,
  output word_t  epc,
`endif
  output state_t fsm_state
);

  state_t state_q;
  state_t state_d;
  redir_t sel;
  word_t  pc_q;
  word_t  pc_d;
  word_t  add_b;
  word_t  add_sum;
`ifdef PC_TRAP_EN
  logic   trap_take;
  word_t  epc_q;
`endif

  // ---------------------------------------------------------------------------
  // Shared adder. Operand A is always pc. Operand B is the branch offset only
  // when the branch is the winning redirect; a halt that arrives together with
  // br_valid still needs pc + INC, so keying on sel rather than on br_valid
  // alone keeps the halt path correct.
  // ---------------------------------------------------------------------------
  assign add_b = (sel == BR) ? br_offset : INC;

  pc_adder #(
    .NAND_TIME (NAND_TIME)
  ) u_pc_adder (
    .a   (pc_q),
    .b   (add_b),
    .sum (add_sum)
  );

  // ---------------------------------------------------------------------------
  // FSM process 1: state register (and the datapath registers it steers).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef PC_TRAP_EN
  // epc records the pc of the instruction (or parked pc) that took the trap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epc_q <= 16'h0000;
    end else if (trap_take) begin
      epc_q <= pc_q;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM process 2: next state and redirect selection.
  // DECIDE priority: (trap) > halt > jmp_valid > br_valid > stall > sequential.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    sel     = HOLD;
`ifdef PC_TRAP_EN
    trap_take = 1'b0;
`endif
    case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          state_d = DECIDE;
        end
      end
      DECIDE: begin
`ifdef PC_TRAP_EN
        if (trap_valid) begin
          trap_take = 1'b1;
          state_d   = FETCH;
        end else
`endif
        if (halt) begin
          // The current instruction retires, so the parked pc points past it.
          sel     = SEQ;
          state_d = HALT;
        end else if (jmp_valid) begin
          sel     = JMP;
          state_d = FETCH;
        end else if (br_valid) begin
          sel     = BR;
          state_d = FETCH;
        end else if (stall) begin
          sel     = HOLD;
          state_d = DECIDE;
        end else begin
          sel     = SEQ;
          state_d = FETCH;
        end
      end
      HALT: begin
`ifdef PC_TRAP_EN
        if (trap_valid) begin
          trap_take = 1'b1;
          state_d   = FETCH;
        end else
`endif
        if (resume) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // Next pc from the redirect selection; trap vector overrides everything.
  always_comb begin
    case (sel)
      SEQ, BR: pc_d = add_sum;
      JMP:     pc_d = jmp_target;
      default: pc_d = pc_q;
    endcase
`ifdef PC_TRAP_EN
    if (trap_take) begin
      pc_d = TRAP_VEC;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: outputs. Purely decoded from the registered state so they
  // follow an asynchronous reset immediately.
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state_q)
      FETCH:   imem_req    = 1'b1;
      DECIDE:  instr_valid = 1'b1;
      HALT:    halted      = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign fsm_state = state_q;
`ifdef PC_TRAP_EN
  assign epc       = epc_q;
`endif

endmodule
